// File: rtl/demux81_deserializer.sv
// Serial-to-parallel lane deserializer: rebuilds one LANES-bit word from LANES
// serial beats (lane 0 first), with valid/ready on both sides and SOF realignment.
module demux81_deserializer #(
  parameter int   SEL_W     = 3,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_bit,
  input  logic                  in_valid,
  input  logic                  in_sof,
  output logic                  in_ready,
  output logic [SEL_W-1:0]      lane,
  output logic [(2**SEL_W)-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sync_err
);

  localparam int               LANES = 2 ** SEL_W;
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(LANES - 1);

  logic [SEL_W-1:0] lane_q, lane_d;
  // The top lane goes straight to out_data, so staging only holds the lower lanes.
  logic [LANES-2:0] staging_q, staging_d;
  logic [LANES-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             sync_err_q, sync_err_d;
  logic             accept;
  logic             complete;

  // Only the completing beat needs a free (or freeing) output slot.
  assign in_ready = !out_valid_q || out_ready || (lane_q != LAST);
  assign accept   = in_valid && in_ready;
  assign complete = accept && !in_sof && (lane_q == LAST);

  always_comb begin
    lane_d     = lane_q;
    staging_d  = staging_q;
    out_data_d = out_data_q;
    sync_err_d = 1'b0;
    if (accept) begin
      if (in_sof) begin
        staging_d[0] = in_bit;
        lane_d       = SEL_W'(1);
        sync_err_d   = (lane_q != '0);
      end else if (lane_q == LAST) begin
        out_data_d = {in_bit, staging_q};
        lane_d     = '0;
      end else begin
        staging_d[lane_q] = in_bit;
        lane_d            = lane_q + SEL_W'(1);
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    if (complete)
      out_valid_d = 1'b1;
    else if (out_ready && out_valid_q)
      out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q      <= '0;
      staging_q   <= {(LANES-1){RESET_VAL}};
      out_data_q  <= {LANES{RESET_VAL}};
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      lane_q      <= lane_d;
      staging_q   <= staging_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign lane      = lane_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_demux81_deserializer.sv
// Directed bench for demux81_deserializer: hand-computed frames, stall, resync,
// gaps, async reset and back-to-back throughput.
module tb_demux81_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_bit, in_valid, in_sof, in_ready;
  logic [2:0] lane;
  logic [7:0] out_data;
  logic       out_valid, out_ready, sync_err;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  demux81_deserializer #(.SEL_W(3), .RESET_VAL(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_ready  (in_ready),
    .lane      (lane),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sync_err  (sync_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // Present one beat and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic send_bit(input logic b, input logic sof);
    int tries;
    tries    = 0;
    in_valid = 1'b1;
    in_bit   = b;
    in_sof   = sof;
    #1;
    while (!in_ready && tries < 50) begin
      @(posedge clk); #1;
      tries++;
    end
    if (tries >= 50) chk("beat_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] v);
    for (int k = 0; k < 8; k++) send_bit(v[k], k == 0);
  endtask

  int          t_prev;
  logic [7:0]  b2b [4] = '{8'h01, 8'h80, 8'h00, 8'hFF};
  logic [7:0]  basic_v;
  logic [7:0]  v5;

  initial begin
    rst = 1'b1; in_bit = 1'b0; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("rst_lane", 32'(lane), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h00);
    chk("rst_sync_err", 32'(sync_err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 rst = 1'b0;

    // Basic frame: bits 1,0,1,1,0,0,1,0 -> 8'h4D
    basic_v = 8'b0100_1101;
    send_frame(basic_v);
    chk("basic_data", 32'(out_data), 32'h4D);
    chk("basic_valid", 32'(out_valid), 32'd1);
    chk("basic_lane", 32'(lane), 32'd0);
    chk("basic_sync_err", 32'(sync_err), 32'd0);
    @(posedge clk); #1;
    chk("basic_valid_drop", 32'(out_valid), 32'd0);

    // Backpressure: A5 sits in the slot while 7 beats of 3C arrive.
    out_ready = 1'b0;
    send_frame(8'hA5);
    chk("bp_first_data", 32'(out_data), 32'hA5);
    v5 = 8'h3C;
    for (int k = 0; k < 7; k++) send_bit(v5[k], k == 0);
    in_valid = 1'b1; in_bit = v5[7]; in_sof = 1'b0;
    #1;
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    chk("bp_lane7", 32'(lane), 32'd7);
    @(posedge clk); #1;
    chk("bp_hold_data", 32'(out_data), 32'hA5);
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_high", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_second_data", 32'(out_data), 32'h3C);
    chk("bp_no_bubble", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    chk("bp_valid_drop", 32'(out_valid), 32'd0);

    // Resync: 3 beats of 1s, then SOF(1), then 7 zeros -> 8'h01.
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("rs_lane3", 32'(lane), 32'd3);
    send_bit(1'b1, 1'b1);
    chk("rs_sync_err_pulse", 32'(sync_err), 32'd1);
    chk("rs_lane1", 32'(lane), 32'd1);
    send_bit(1'b0, 1'b0);
    chk("rs_sync_err_clear", 32'(sync_err), 32'd0);
    for (int k = 2; k < 8; k++) send_bit(1'b0, 1'b0);
    chk("rs_data", 32'(out_data), 32'h01);
    chk("rs_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;

    // Idle gaps; out_ready held low so the FF frame stays pending into the next test.
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      send_bit(1'b1, k == 0);
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
      if (k < 7) chk("gap_lane", 32'(lane), 32'(k + 1));
    end
    chk("gap_data", 32'(out_data), 32'hFF);
    chk("gap_valid", 32'(out_valid), 32'd1);

    // Mid-frame async reset after 5 beats.
    for (int k = 0; k < 5; k++) send_bit(1'b1, k == 0);
    chk("mr_lane5", 32'(lane), 32'd5);
    #3 rst = 1'b1;
    #1;
    chk("mr_lane0", 32'(lane), 32'd0);
    chk("mr_valid0", 32'(out_valid), 32'd0);
    chk("mr_data0", 32'(out_data), 32'h00);
    @(posedge clk); #1 rst = 1'b0;
    out_ready = 1'b1;
    send_frame(8'h5A);
    chk("mr_clean_data", 32'(out_data), 32'h5A);
    chk("mr_clean_valid", 32'(out_valid), 32'd1);

    // Back-to-back frames, continuous valid: one frame every 8 cycles.
    t_prev = cyc;
    for (int f = 0; f < 4; f++) begin
      send_frame(b2b[f]);
      chk("b2b_data", 32'(out_data), 32'(b2b[f]));
      chk("b2b_valid", 32'(out_valid), 32'd1);
      chk("b2b_spacing", 32'(cyc - t_prev), 32'd8);
      t_prev = cyc;
    end
    @(posedge clk); #1;
    chk("b2b_valid_drop", 32'(out_valid), 32'd0);
    chk("b2b_sync_err", 32'(sync_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
